// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
// Holds the FSM state encoding, requester tags and access-length decode.
package mem_ctrl_pkg;

  localparam int ADDR_LEN = 32;
  localparam int REG_LEN  = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic {
    PORT_DATA = 1'b0,
    PORT_IF   = 1'b1
  } port_e;

  // Any length code other than 1 or 2 bytes is served as a full word.
  function automatic logic [2:0] len_decode(input logic [2:0] nb);
    logic [2:0] len;
    case (nb)
      3'b001:  len = 3'd1;
      3'b010:  len = 3'd2;
      default: len = 3'd4;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial controller between the pipeline and a single-port 8-bit RAM.
// Data port wins over instruction fetch; completion is a one-cycle done pulse.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rdy,
  input  logic                if_req_i,
  input  logic [ADDR_LEN-1:0] if_addr_i,
  output logic [REG_LEN-1:0]  inst_o,
  output logic                if_enable_o,
  input  logic [ADDR_LEN-1:0] mem_addr_i,
  input  logic                load_or_not,
  input  logic                store_or_not,
  input  logic [2:0]          num_of_bytes,
  input  logic [REG_LEN-1:0]  store_data,
  output logic [REG_LEN-1:0]  load_data,
  output logic                mem_enable,
  output logic [ADDR_LEN-1:0] ram_a,
  output logic [7:0]          ram_dout,
  output logic                ram_wr,
  input  logic [7:0]          ram_din
);

  state_e              state_q;
  port_e               port_q;
  logic [2:0]          cnt_q;
  logic [2:0]          len_q;
  logic [ADDR_LEN-1:0] base_q;
  logic [REG_LEN-1:0]  wdata_q;
  logic [REG_LEN-1:0]  rbuf_q;
  logic [ADDR_LEN-1:0] ram_a_q;
  logic [7:0]          ram_dout_q;
  logic                ram_wr_q;
  logic [REG_LEN-1:0]  load_data_q;
  logic [REG_LEN-1:0]  inst_q;
  logic                mem_en_q;
  logic                if_en_q;

  logic [2:0]          cnt_d;
  logic [ADDR_LEN-1:0] next_addr_d;
  logic [REG_LEN-1:0]  rbuf_d;
  logic [7:0]          wbyte_d;

  assign cnt_d       = cnt_q + 3'd1;
  assign next_addr_d = base_q + {29'd0, cnt_d};

  // Byte returned now belongs to the address issued one cycle earlier (index cnt-1).
  always_comb begin
    rbuf_d = rbuf_q;
    case (cnt_q)
      3'd1:    rbuf_d[7:0]   = ram_din;
      3'd2:    rbuf_d[15:8]  = ram_din;
      3'd3:    rbuf_d[23:16] = ram_din;
      3'd4:    rbuf_d[31:24] = ram_din;
      default: rbuf_d        = rbuf_q;
    endcase
  end

  // Payload byte for the next write cycle.
  always_comb begin
    case (cnt_d[1:0])
      2'd0:    wbyte_d = wdata_q[7:0];
      2'd1:    wbyte_d = wdata_q[15:8];
      2'd2:    wbyte_d = wdata_q[23:16];
      default: wbyte_d = wdata_q[31:24];
    endcase
  end

  // Arbiter, sequencer and output registers; everything freezes while rdy is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      port_q      <= PORT_DATA;
      cnt_q       <= 3'd0;
      len_q       <= 3'd0;
      base_q      <= 32'd0;
      wdata_q     <= 32'd0;
      rbuf_q      <= 32'd0;
      ram_a_q     <= 32'd0;
      ram_dout_q  <= 8'd0;
      ram_wr_q    <= 1'b0;
      load_data_q <= 32'd0;
      inst_q      <= 32'd0;
      mem_en_q    <= 1'b0;
      if_en_q     <= 1'b0;
    end else if (rdy) begin
      case (state_q)
        ST_IDLE: begin
          mem_en_q <= 1'b0;
          if_en_q  <= 1'b0;
          ram_wr_q <= 1'b0;
          if (load_or_not || store_or_not) begin
            base_q  <= mem_addr_i;
            len_q   <= len_decode(num_of_bytes);
            wdata_q <= store_data;
            port_q  <= PORT_DATA;
            cnt_q   <= 3'd0;
            rbuf_q  <= 32'd0;
            ram_a_q <= mem_addr_i;
            if (store_or_not) begin
              ram_dout_q <= store_data[7:0];
              ram_wr_q   <= 1'b1;
              state_q    <= ST_WRITE;
            end else begin
              state_q <= ST_READ;
            end
          end else if (if_req_i) begin
            base_q  <= if_addr_i;
            len_q   <= 3'd4;
            port_q  <= PORT_IF;
            cnt_q   <= 3'd0;
            rbuf_q  <= 32'd0;
            ram_a_q <= if_addr_i;
            state_q <= ST_READ;
          end
        end
        ST_READ: begin
          cnt_q  <= cnt_d;
          rbuf_q <= rbuf_d;
          if (cnt_q == len_q) begin
            state_q <= ST_DONE;
            if (port_q == PORT_DATA) begin
              load_data_q <= rbuf_d;
              mem_en_q    <= 1'b1;
            end else begin
              inst_q  <= rbuf_d;
              if_en_q <= 1'b1;
            end
          end else if (cnt_d < len_q) begin
            ram_a_q <= next_addr_d;
          end
        end
        ST_WRITE: begin
          if (cnt_d < len_q) begin
            cnt_q      <= cnt_d;
            ram_a_q    <= next_addr_d;
            ram_dout_q <= wbyte_d;
            ram_wr_q   <= 1'b1;
          end else begin
            ram_wr_q <= 1'b0;
            mem_en_q <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: begin
          mem_en_q <= 1'b0;
          if_en_q  <= 1'b0;
          cnt_q    <= 3'd0;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign ram_a       = ram_a_q;
  assign ram_dout    = ram_dout_q;
  assign ram_wr      = ram_wr_q & rdy;
  assign load_data   = load_data_q;
  assign inst_o      = inst_q;
  assign mem_enable  = mem_en_q;
  assign if_enable_o = if_en_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: directed table, hand-written corner sequences
// and randomized traffic against a byte-array reference model.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] inst_o;
  logic        if_enable_o;
  logic [31:0] mem_addr_i;
  logic        load_or_not;
  logic        store_or_not;
  logic [2:0]  num_of_bytes;
  logic [31:0] store_data;
  logic [31:0] load_data;
  logic        mem_enable;
  logic [31:0] ram_a;
  logic [7:0]  ram_dout;
  logic        ram_wr;
  logic [7:0]  ram_din = 8'h00;

  int n_total = 0;
  int n_pass  = 0;

  mem_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .inst_o(inst_o), .if_enable_o(if_enable_o),
    .mem_addr_i(mem_addr_i), .load_or_not(load_or_not), .store_or_not(store_or_not),
    .num_of_bytes(num_of_bytes), .store_data(store_data), .load_data(load_data),
    .mem_enable(mem_enable), .ram_a(ram_a), .ram_dout(ram_dout), .ram_wr(ram_wr),
    .ram_din(ram_din)
  );

  always #5 clk = ~clk;

  // Environment RAM (stalls together with the core) and the reference byte image.
  logic [7:0]  ram [logic [31:0]];
  logic [7:0]  model_mem [logic [31:0]];
  logic [31:0] wr_a [$];
  logic [7:0]  wr_d [$];

  function automatic logic [7:0] env_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  function automatic logic [7:0] model_rd(input logic [31:0] a);
    return model_mem.exists(a) ? model_mem[a] : 8'h00;
  endfunction

  always @(posedge clk) begin
    if (rdy) ram_din <= env_rd(ram_a);
    if (ram_wr) begin
      ram[ram_a] = ram_dout;
      wr_a.push_back(ram_a);
      wr_d.push_back(ram_dout);
    end
  end

  function automatic int model_len(input int op, input logic [2:0] nb);
    if (op == 2) return 4;
    if (nb == 3'b001) return 1;
    if (nb == 3'b010) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] a, input int n);
    logic [31:0] r;
    logic [31:0] ak;
    r = 32'h0;
    for (int k = 0; k < n; k++) begin
      ak = a + k;
      r[k*8 +: 8] = model_rd(ak);
    end
    return r;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    ram[a]       = b;
    model_mem[a] = b;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Drives one request from an IDLE cycle and returns 1 cycle after the done pulse.
  task automatic do_op(input int op, input logic [31:0] addr, input logic [2:0] nb,
                       input logic [31:0] sd, output logic [31:0] data,
                       output int lat, output int log_start);
    bit done;
    log_start = wr_a.size();
    case (op)
      0:       begin load_or_not = 1'b1; mem_addr_i = addr; num_of_bytes = nb; end
      1:       begin store_or_not = 1'b1; mem_addr_i = addr; num_of_bytes = nb; store_data = sd; end
      default: begin if_req_i = 1'b1; if_addr_i = addr; end
    endcase
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      done = (op == 2) ? if_enable_o : mem_enable;
    end
    data = (op == 2) ? inst_o : load_data;
    if (!done) lat = -1;
    load_or_not  = 1'b0;
    store_or_not = 1'b0;
    if_req_i     = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_check(input string tag, input int op, input logic [31:0] addr,
                           input logic [2:0] nb, input logic [31:0] sd,
                           input logic [31:0] exp_data, input int exp_lat);
    logic [31:0] data;
    int lat, start, n;
    n = model_len(op, nb);
    do_op(op, addr, nb, sd, data, lat, start);
    check({tag, " latency"}, lat, exp_lat);
    if (op == 1) begin
      check({tag, " write count"}, wr_a.size() - start, n);
      for (int k = 0; k < n && start + k < wr_a.size(); k++) begin
        check($sformatf("%s wr%0d addr", tag, k), wr_a[start+k], addr + k);
        check($sformatf("%s wr%0d byte", tag, k), {24'h0, wr_d[start+k]}, {24'h0, sd[k*8 +: 8]});
      end
    end else begin
      check({tag, " data"}, data, exp_data);
      check({tag, " write count"}, wr_a.size() - start, 0);
    end
  endtask

  typedef struct {
    int          op;
    logic [31:0] addr;
    logic [2:0]  nb;
    logic [31:0] sd;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t tbl [13];

  initial begin
    logic [31:0] data, addr, sd, exp;
    int lat, start, op, n;
    logic [2:0] nb;

    tbl[0]  = '{0, 32'h0000_0100, 3'd4, 32'h0,          32'h4433_2211, 6};
    tbl[1]  = '{1, 32'h0000_0200, 3'd2, 32'hDEAD_BEEF,  32'h0,         3};
    tbl[2]  = '{0, 32'h0000_0200, 3'd2, 32'h0,          32'h0000_BEEF, 4};
    tbl[3]  = '{0, 32'h0000_0101, 3'd1, 32'h0,          32'h0000_0022, 3};
    tbl[4]  = '{2, 32'h0000_0100, 3'd0, 32'h0,          32'h4433_2211, 6};
    tbl[5]  = '{1, 32'h0000_0102, 3'd1, 32'h0000_00AA,  32'h0,         2};
    tbl[6]  = '{0, 32'h0000_0100, 3'd4, 32'h0,          32'h44AA_2211, 6};
    tbl[7]  = '{0, 32'h0000_0100, 3'd3, 32'h0,          32'h44AA_2211, 6};
    tbl[8]  = '{0, 32'h0000_0200, 3'd7, 32'h0,          32'h0000_BEEF, 6};
    tbl[9]  = '{0, 32'hFFFF_FFFF, 3'd1, 32'h0,          32'h0000_00AB, 3};
    tbl[10] = '{0, 32'hFFFF_FFFF, 3'd2, 32'h0,          32'h0000_CDAB, 4};
    tbl[11] = '{1, 32'h0000_01FE, 3'd4, 32'h0102_0304,  32'h0,         5};
    tbl[12] = '{0, 32'h0000_0200, 3'd2, 32'h0,          32'h0000_0102, 4};

    preload(32'h100, 8'h11); preload(32'h101, 8'h22);
    preload(32'h102, 8'h33); preload(32'h103, 8'h44);
    preload(32'hFFFF_FFFF, 8'hAB); preload(32'h0, 8'hCD);

    rst_n = 1'b0; rdy = 1'b1;
    if_req_i = 1'b0; if_addr_i = 32'h0; mem_addr_i = 32'h0;
    load_or_not = 1'b0; store_or_not = 1'b0; num_of_bytes = 3'd0; store_data = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset ram_a", ram_a, 32'h0);
    check("reset ram_dout", {24'h0, ram_dout}, 32'h0);
    check("reset ram_wr", {31'h0, ram_wr}, 32'h0);
    check("reset load_data", load_data, 32'h0);
    check("reset inst_o", inst_o, 32'h0);
    check("reset enables", {30'h0, mem_enable, if_enable_o}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 13; i++)
      run_check($sformatf("tbl%0d", i), tbl[i].op, tbl[i].addr, tbl[i].nb, tbl[i].sd,
                tbl[i].exp, tbl[i].lat);
    // Keep the reference image in step with the table's stores.
    model_mem[32'h200] = 8'h02; model_mem[32'h201] = 8'h01;
    model_mem[32'h1FE] = 8'h04; model_mem[32'h1FF] = 8'h03; model_mem[32'h102] = 8'hAA;

    // Data and fetch raised together: LB first, fetch accepted the cycle after DONE.
    if_req_i = 1'b1; if_addr_i = 32'h100;
    load_or_not = 1'b1; mem_addr_i = 32'h101; num_of_bytes = 3'd1;
    lat = 0;
    while (!mem_enable && !if_enable_o && lat < 20) begin @(posedge clk); #1; lat++; end
    check("prio LB latency", lat, 3);
    check("prio fetch not first", {31'h0, if_enable_o}, 32'h0);
    check("prio LB data", load_data, 32'h0000_0022);
    load_or_not = 1'b0;
    lat = 0;
    while (!if_enable_o && lat < 20) begin @(posedge clk); #1; lat++; end
    check("prio fetch after done", lat, 7);
    check("prio fetch data", inst_o, 32'h44AA_2211);
    if_req_i = 1'b0;
    @(posedge clk); #1;

    // rdy low for 3 cycles in the middle of a LW.
    start = wr_a.size();
    load_or_not = 1'b1; mem_addr_i = 32'h100; num_of_bytes = 3'd4;
    lat = 0;
    while (!mem_enable && lat < 30) begin
      @(posedge clk); #1; lat++;
      if (lat == 2) begin
        rdy = 1'b0;
        repeat (3) begin @(posedge clk); #1; lat++; end
        check("stall ram_a held", ram_a, 32'h101);
        rdy = 1'b1;
      end
    end
    check("stall LW latency", lat, 9);
    check("stall LW data", load_data, 32'h44AA_2211);
    check("stall no writes", wr_a.size() - start, 0);
    load_or_not = 1'b0;
    @(posedge clk); #1;

    // Reset after the second byte of a SW has been written.
    preload(32'h300, 8'h10); preload(32'h301, 8'h20);
    preload(32'h302, 8'h30); preload(32'h303, 8'h40);
    start = wr_a.size();
    store_or_not = 1'b1; mem_addr_i = 32'h300; num_of_bytes = 3'd4; store_data = 32'hA1B2_C3D4;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("rst ram_wr", {31'h0, ram_wr}, 32'h0);
    check("rst ram_a", ram_a, 32'h0);
    check("rst ram_dout", {24'h0, ram_dout}, 32'h0);
    check("rst load_data", load_data, 32'h0);
    check("rst partial writes", wr_a.size() - start, 2);
    store_or_not = 1'b0;
    model_mem[32'h300] = 8'hD4; model_mem[32'h301] = 8'hC3;
    @(posedge clk); #1;
    check("rst no mem_enable", {31'h0, mem_enable}, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_check("post-rst LW", 0, 32'h300, 3'd4, 32'h0, 32'h4030_C3D4, 6);

    // Randomized traffic against the reference image.
    for (int a = 0; a < 68; a++) preload(32'h4000 + a, 8'($urandom));
    for (int i = 0; i < 40; i++) begin
      op   = $urandom_range(0, 2);
      addr = 32'h4000 + $urandom_range(0, 60);
      nb   = 3'($urandom_range(0, 7));
      sd   = $urandom;
      n    = model_len(op, nb);
      exp  = model_load(addr, n);
      run_check($sformatf("rnd%0d op%0d", i, op), op, addr, nb, sd, exp,
                (op == 1) ? n + 1 : n + 2);
      if (op == 1)
        for (int k = 0; k < n; k++) model_mem[addr + k] = sd[k*8 +: 8];
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
